// File: rtl/narrow_wide_fifo_ctrl.sv
// Narrow-in / wide-out FIFO controller driving an external mixed-width dual-port RAM.
// Port A takes narrow pushes; port B prefetches complete wide words to the consumer.
module narrow_wide_fifo_ctrl #(
  parameter  int unsigned DATA_WIDTH_A = 8,
  parameter  int unsigned ADDR_WIDTH_A = 6,
  parameter  int unsigned ADDR_WIDTH_B = 4,
  localparam int unsigned DATA_WIDTH_B = DATA_WIDTH_A * (1 << (ADDR_WIDTH_A - ADDR_WIDTH_B))
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DATA_WIDTH_A-1:0] IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [DATA_WIDTH_B-1:0] OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [ADDR_WIDTH_A:0]   LEVEL,
  output logic [ADDR_WIDTH_A-1:0] RAM_ADDR_A,
  output logic [DATA_WIDTH_A-1:0] RAM_DI_A,
  output logic                    RAM_WE_A,
  output logic [ADDR_WIDTH_B-1:0] RAM_ADDR_B,
  output logic                    RAM_WE_B,
  output logic [DATA_WIDTH_B-1:0] RAM_DI_B,
  input  logic [DATA_WIDTH_B-1:0] RAM_DO_B
);

  localparam int unsigned RATIO_LOG2 = ADDR_WIDTH_A - ADDR_WIDTH_B;
  localparam int unsigned RATIO      = 1 << RATIO_LOG2;
  localparam int unsigned LW         = ADDR_WIDTH_A + 1;
  localparam int unsigned AVW        = ADDR_WIDTH_B + 1;
  localparam int unsigned CAP        = 1 << ADDR_WIDTH_A;

  typedef enum logic {ST_EMPTY, ST_VALID} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH_A-1:0] r_wr_ptr;
  logic [ADDR_WIDTH_B-1:0] r_rd_word;
  logic [LW-1:0]           r_level;
  logic [LW-1:0]           w_level_nxt;
  logic [AVW-1:0]          w_avail;
  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_pop;

  // Only whole wide words count as available; a partial word is never read out.
  assign w_avail    = r_level[LW-1:RATIO_LOG2];
  assign w_in_ready = !RESET && (r_level != LW'(CAP));
  assign w_push     = IN_VALID & w_in_ready;
  assign w_pop      = (r_state == ST_VALID) & OUT_READY;
  assign w_level_nxt = r_level + LW'(w_push) - (w_pop ? LW'(RATIO) : LW'(0));

  // Head FSM: EMPTY issues the head read, VALID presents RAM_DO_B.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_avail != AVW'(0)) w_state_nxt = ST_VALID;
      ST_VALID: if (w_pop && (w_avail == AVW'(1))) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_EMPTY;
      r_wr_ptr  <= '0;
      r_rd_word <= '0;
      r_level   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      if (w_push) r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH_A'(1);
      if (w_pop)  r_rd_word <= r_rd_word + ADDR_WIDTH_B'(1);
    end
  end

  // On pop the next word is addressed now so it lands back-to-back next cycle.
  assign RAM_ADDR_B = w_pop ? (r_rd_word + ADDR_WIDTH_B'(1)) : r_rd_word;
  assign RAM_WE_B   = 1'b0;
  assign RAM_DI_B   = '0;
  assign RAM_ADDR_A = r_wr_ptr;
  assign RAM_DI_A   = IN_DATA;
  assign RAM_WE_A   = w_push;

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = (r_state == ST_VALID);
  assign OUT_DATA  = RAM_DO_B;
  assign LEVEL     = r_level;

endmodule

// File: tb/tb_narrow_wide_fifo_ctrl.sv
// Directed bench for narrow_wide_fifo_ctrl with a behavioural mixed-width RAM and
// a packed-word scoreboard fed from accepted pushes and drained on pops.
module tb_narrow_wide_fifo_ctrl;

  localparam int unsigned DWA   = 8;
  localparam int unsigned AWA   = 6;
  localparam int unsigned AWB   = 4;
  localparam int unsigned RATIO = 4;
  localparam int unsigned DWB   = DWA * RATIO;
  localparam int unsigned CAP   = 64;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [DWA-1:0] IN_DATA = '0;
  logic           IN_VALID = 1'b0;
  logic           IN_READY;
  logic [DWB-1:0] OUT_DATA;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
  logic [AWA:0]   LEVEL;
  logic [AWA-1:0] RAM_ADDR_A;
  logic [DWA-1:0] RAM_DI_A;
  logic           RAM_WE_A;
  logic [AWB-1:0] RAM_ADDR_B;
  logic           RAM_WE_B;
  logic [DWB-1:0] RAM_DI_B;
  logic [DWB-1:0] RAM_DO_B;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;

  narrow_wide_fifo_ctrl #(
    .DATA_WIDTH_A(DWA), .ADDR_WIDTH_A(AWA), .ADDR_WIDTH_B(AWB)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .LEVEL(LEVEL),
    .RAM_ADDR_A(RAM_ADDR_A), .RAM_DI_A(RAM_DI_A), .RAM_WE_A(RAM_WE_A),
    .RAM_ADDR_B(RAM_ADDR_B), .RAM_WE_B(RAM_WE_B), .RAM_DI_B(RAM_DI_B),
    .RAM_DO_B(RAM_DO_B)
  );

  always #5 CLK = ~CLK;

  // Mixed-width RAM: wide word b holds narrow elements b*RATIO+k, element 0 in the LSBs.
  logic [DWA-1:0] mem [CAP];
  always @(posedge CLK) begin
    if (RAM_WE_A) mem[RAM_ADDR_A] <= RAM_DI_A;
    for (int k = 0; k < RATIO; k++)
      RAM_DO_B[k*DWA +: DWA] <= mem[int'(RAM_ADDR_B) * RATIO + k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and occupancy model, evaluated mid-cycle when inputs are stable.
  logic [DWA-1:0] byte_q[$];
  logic [DWB-1:0] word_q[$];
  int             m_level = 0;
  logic           prev_hold = 1'b0;
  logic [DWB-1:0] prev_data = '0;

  always @(negedge CLK) begin
    if (RESET) begin
      m_level = 0;
      byte_q.delete();
      word_q.delete();
      prev_hold = 1'b0;
    end else begin
      chk("level", 32'(LEVEL), 32'(m_level));
      if (prev_hold) begin
        chk("hold_valid", 32'(OUT_VALID), 32'd1);
        chk("hold_data", OUT_DATA, prev_data);
      end
      if (IN_VALID && IN_READY) begin
        byte_q.push_back(IN_DATA);
        m_level++;
        if (byte_q.size() == RATIO) begin
          logic [DWB-1:0] w;
          for (int k = 0; k < RATIO; k++) w[k*DWA +: DWA] = byte_q[k];
          byte_q.delete();
          word_q.push_back(w);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        n_pops++;
        m_level -= RATIO;
        if (word_q.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
        else chk("pop_data", OUT_DATA, word_q.pop_front());
      end
      prev_hold = OUT_VALID && !OUT_READY;
      prev_data = OUT_DATA;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    cyc();
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    cyc();
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_we_a", 32'(RAM_WE_A), 32'd0);
    RESET = 1'b0;
    #1;
    chk("rst_in_ready_after", 32'(IN_READY), 32'd1);
  endtask

  initial begin
    logic [DWA-1:0] d;
    logic           acc;
    int             sent;
    int             pops0;

    // First word latency
    do_reset();
    IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_DATA = 8'(i);
      cyc();
      if (i == 2) chk("t1_no_partial", 32'(OUT_VALID), 32'd0);
    end
    IN_VALID = 1'b0;
    chk("t1_valid_n1", 32'(OUT_VALID), 32'd0);
    chk("t1_level", 32'(LEVEL), 32'd4);
    cyc();
    chk("t1_valid_n2", 32'(OUT_VALID), 32'd1);
    chk("t1_data", OUT_DATA, 32'h03020100);
    OUT_READY = 1'b1;
    cyc();
    OUT_READY = 1'b0;
    chk("t1_empty", 32'(OUT_VALID), 32'd0);

    // Fill to capacity with the consumer stalled
    d = 8'h40;
    IN_VALID = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      IN_DATA = d;
      cyc();
      d++;
    end
    chk("t2_full_ready", 32'(IN_READY), 32'd0);
    chk("t2_full_level", 32'(LEVEL), 32'(CAP));
    IN_DATA = 8'hEE;
    cyc();
    chk("t2_reject_level", 32'(LEVEL), 32'(CAP));
    chk("t2_reject_we", 32'(RAM_WE_A), 32'd0);

    // Back-to-back drain from full while pushing
    IN_DATA = d;
    OUT_READY = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("t3_valid", 32'(OUT_VALID), 32'd1);
      acc = IN_READY;
      cyc();
      if (acc) begin d++; IN_DATA = d; end
      if (j == 0) chk("t3_ready_rise", 32'(IN_READY), 32'd1);
      chk("t3_level", 32'(LEVEL), (j == 0) ? 32'd60 : 32'(60 - 3 * j));
    end
    IN_VALID = 1'b0;
    repeat (12) cyc();
    chk("t3_drain_level", 32'(LEVEL), 32'd3);
    chk("t3_drain_valid", 32'(OUT_VALID), 32'd0);

    // Random-stall streaming across pointer wrap
    do_reset();
    sent = 0;
    for (int c = 0; c < 3000 && (sent < 200 || word_q.size() != 0); c++) begin
      IN_VALID  = (sent < 200) && ($urandom_range(0, 3) != 0);
      IN_DATA   = 8'($urandom);
      OUT_READY = ($urandom_range(0, 2) != 0);
      acc = IN_VALID && IN_READY;
      cyc();
      if (acc) sent++;
    end
    chk("t4_complete", 32'((sent == 200) && (word_q.size() == 0)), 32'd1);
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    cyc();
    chk("t4_level", 32'(LEVEL), 32'd0);
    chk("t4_valid", 32'(OUT_VALID), 32'd0);

    // Six pushes: one word out, two elements stranded
    pops0 = n_pops;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      IN_DATA = 8'(8'hC0 + i);
      cyc();
    end
    IN_VALID = 1'b0;
    repeat (20) cyc();
    chk("t5_one_word", 32'(n_pops - pops0), 32'd1);
    chk("t5_valid", 32'(OUT_VALID), 32'd0);
    chk("t5_level", 32'(LEVEL), 32'd2);

    // Reset while presenting with LEVEL=20
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 18; i++) begin
      IN_DATA = 8'(8'hD0 + i);
      cyc();
    end
    IN_VALID = 1'b0;
    cyc();
    cyc();
    chk("t6_pre_level", 32'(LEVEL), 32'd20);
    chk("t6_pre_valid", 32'(OUT_VALID), 32'd1);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    #1;
    chk("t6_valid", 32'(OUT_VALID), 32'd0);
    chk("t6_level", 32'(LEVEL), 32'd0);
    chk("t6_in_ready", 32'(IN_READY), 32'd1);
    IN_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IN_DATA = 8'(8'hA0 + i);
      cyc();
    end
    IN_VALID = 1'b0;
    cyc();
    chk("t6_repack_valid", 32'(OUT_VALID), 32'd1);
    chk("t6_repack_data", OUT_DATA, 32'hA3A2A1A0);
    OUT_READY = 1'b1;
    cyc();
    OUT_READY = 1'b0;
    cyc();
    chk("t6_final_level", 32'(LEVEL), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/narrow_wide_fifo_ctrl.md
Name: narrow_wide_fifo_ctrl

Overview:
- Controller that turns an external mixed-width true dual-port block RAM into a narrow-in / wide-out FIFO.
- Port A of the RAM takes narrow writes from a valid/ready producer; port B serves wide reads to a valid/ready consumer.
- Owns the pointers, occupancy, full/empty and read prefetch. Sits between a narrow stream source and a wide consumer, e.g. byte stream to word packing.

Parameters:
- DATA_WIDTH_A, 8, narrow element width in bits.
- ADDR_WIDTH_A, 6, narrow address width.
- ADDR_WIDTH_B, 4, wide address width. Must be <= ADDR_WIDTH_A.
- Derived (not parameters): RATIO = 1<<(ADDR_WIDTH_A-ADDR_WIDTH_B); DATA_WIDTH_B = DATA_WIDTH_A*RATIO; CAP = 1<<ADDR_WIDTH_A narrow elements.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  DATA_WIDTH_A  narrow element to enqueue.
- IN_VALID  in  1  producer offers IN_DATA.
- IN_READY  out  1  space for one element.
- OUT_DATA  out  DATA_WIDTH_B  wide word at FIFO head; element 0 (oldest) in the LSBs.
- OUT_VALID  out  1  OUT_DATA is a complete word.
- OUT_READY  in  1  consumer accepts OUT_DATA.
- LEVEL  out  ADDR_WIDTH_A+1  stored narrow elements, registered.
- RAM_ADDR_A  out  ADDR_WIDTH_A  RAM port A address.
- RAM_DI_A  out  DATA_WIDTH_A  RAM port A write data.
- RAM_WE_A  out  1  RAM port A write enable.
- RAM_ADDR_B  out  ADDR_WIDTH_B  RAM port B address.
- RAM_WE_B  out  1  tied 0.
- RAM_DI_B  out  DATA_WIDTH_B  tied 0.
- RAM_DO_B  in  DATA_WIDTH_B  RAM port B registered read data, 1-cycle latency.

Behaviour:
- Clocking and reset: one clock, CLK; reset is synchronous and active-high on RESET.
- Reset state: wr_ptr=0, rd_word=0, LEVEL=0, state=EMPTY, OUT_VALID=0, RAM_WE_A=0.
  - IN_READY=0 while RESET is high; 1 from the first cycle after reset.
  - Reset mid-operation discards all contents; RAM contents are not cleared.
- Push:
  - push = IN_VALID & IN_READY.
  - RAM_WE_A=push, RAM_ADDR_A=wr_ptr (ADDR_WIDTH_A bits, wraps modulo CAP), RAM_DI_A=IN_DATA.
  - wr_ptr increments on push.
- Full: IN_READY = (LEVEL != CAP), from registered LEVEL only. No combinational path from OUT_READY.
- Available words: avail = LEVEL / RATIO (floor). A partially filled word is never presented.
- Pop: pop = OUT_VALID & OUT_READY. rd_word increments on pop, wrapping modulo 1<<ADDR_WIDTH_B.
- LEVEL update: next = LEVEL + push - RATIO*pop, computed in ADDR_WIDTH_A+1 bits. Simultaneous push and pop are legal.
- RAM_ADDR_B = pop ? rd_word+1 : rd_word (combinational). Port B reads every cycle; no RAM read enable.
- Head FSM, states EMPTY and VALID:
  - EMPTY: OUT_VALID=0. If avail>0, go to VALID; the read of rd_word issued this cycle lands in RAM_DO_B next cycle.
  - VALID: OUT_VALID=1, OUT_DATA=RAM_DO_B.
    - Without pop: the same address is re-read, so OUT_DATA stays stable.
    - On pop with avail>=2: stay VALID; the next word is already addressed. This gives back-to-back throughput of 1 wide word per cycle.
    - On pop with avail==1: go to EMPTY.
- Hazard freedom:
  - A word is read only after LEVEL (registered) shows it complete, so its last narrow write committed at least one edge earlier.
  - Port A never writes a word that is presented or counted in avail, because LEVEL<=CAP.
  - The RAM's same-address read-during-write behaviour is therefore never exercised.
- Latency: the last narrow push of a word at edge N gives LEVEL update at N, read issued in cycle N..N+1, OUT_VALID=1 in the cycle after edge N+1. Minimum 2 cycles from last push to OUT_VALID.
- Freed space: a pop at edge N raises IN_READY from the cycle after edge N.
- Wrap-around: both pointers wrap silently. Occupancy is tracked only by LEVEL.

Test Plan:
- Reset, then push 0x00..0x03 (defaults, RATIO=4) -> OUT_VALID=0 after 3 pushes; OUT_DATA=0x03020100 valid exactly 2 cycles after 4th push edge; LEVEL=4.
- Fill with 64 pushes, OUT_READY=0 -> IN_READY=0 once LEVEL=64; a 65th IN_VALID is not accepted; LEVEL stays 64.
- Full FIFO, OUT_READY=1 held, IN_VALID=1 held -> 16 words popped on 16 consecutive cycles, values in order; IN_READY rises the cycle after the first pop; LEVEL follows +1-4 per cycle.
- Continuous streaming of 200 elements with random IN_VALID/OUT_READY stalls -> the wide output sequence equals the packed input across pointer wrap; OUT_DATA is stable while OUT_VALID & !OUT_READY.
- 6 pushes then idle -> exactly one word presented; after it pops, OUT_VALID=0 and LEVEL=2 indefinitely.
- RESET asserted for 1 cycle while VALID with LEVEL=20 -> next cycle OUT_VALID=0, LEVEL=0, IN_READY=1; subsequent pushes repack from element 0.
